// File: rtl/riscv_instr_mem_resp.sv
// Instruction memory responder: combinational grant with optional grant latency,
// 2-deep in-order response queue, backdoor load port. Optional macro: RISCV_IMEM_ERR_EN.
module riscv_instr_mem_resp #(
  parameter int MEM_WORDS  = 1024,
  parameter int GNT_LAT    = 0,
  parameter int RVALID_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
`ifdef RISCV_IMEM_ERR_EN
  output logic        instr_err_o,
`endif
  input  logic        load_we_i,
  input  logic [31:0] load_addr_i,
  input  logic [31:0] load_wdata_i,
  output logic        busy_o
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int GW = $clog2(GNT_LAT + 2);
  localparam logic [3:0]    CNT_INIT  = 4'(RVALID_LAT - 1);
  localparam logic [GW-1:0] GNT_LAT_C = GW'(GNT_LAT);

  typedef enum logic [0:0] {
    G_IDLE = 1'b0,
    G_WAIT = 1'b1
  } gstate_e;

  typedef struct packed {
    logic          vld;
    logic          err;
    logic [AW-1:0] idx;
    logic [3:0]    cnt;
  } entry_t;

  logic [31:0] mem_q [MEM_WORDS];

  gstate_e       state_q, state_d;
  logic [GW-1:0] wcnt_q, wcnt_d;
  entry_t        q_q [2];
  entry_t        q_d [2];
  entry_t        sh_s [2];
  entry_t        push_s;

  logic lat_met_s;
  logic slot_avail_s;
  logic retire_s;
  logic gnt_s;
  logic push_err_s;
  logic unused_s;

`ifdef RISCV_IMEM_ERR_EN
  assign push_err_s = |instr_addr_i[31:AW+2];
  assign unused_s   = ^{instr_addr_i[1:0], load_addr_i[1:0], load_addr_i[31:AW+2]};
`else
  assign push_err_s = 1'b0;
  assign unused_s   = ^{instr_addr_i[1:0], instr_addr_i[31:AW+2],
                        load_addr_i[1:0], load_addr_i[31:AW+2]};
`endif

  // Head entry 0 is always the oldest; entry 1 valid implies entry 0 valid.
  assign retire_s     = q_q[0].vld && (q_q[0].cnt == 4'd0);
  assign slot_avail_s = !q_q[1].vld || retire_s;
  assign lat_met_s    = (GNT_LAT == 0) ? 1'b1
                      : ((state_q == G_WAIT) && (wcnt_q >= GNT_LAT_C));
  assign gnt_s        = rst_n && instr_req_i && lat_met_s && slot_avail_s;

  assign push_s = '{vld: 1'b1, err: push_err_s, idx: instr_addr_i[AW+1:2], cnt: CNT_INIT};

  // Grant FSM next state: wcnt_q counts consecutive req-high cycles since leaving G_IDLE.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      G_IDLE: begin
        if (instr_req_i && (GNT_LAT != 0)) begin
          state_d = G_WAIT;
          wcnt_d  = GW'(1);
        end else begin
          wcnt_d  = '0;
        end
      end
      G_WAIT: begin
        if (!instr_req_i || gnt_s) begin
          state_d = G_IDLE;
          wcnt_d  = '0;
        end else if (wcnt_q < GNT_LAT_C) begin
          wcnt_d  = wcnt_q + GW'(1);
        end else begin
          wcnt_d  = wcnt_q;
        end
      end
      default: begin
        state_d = G_IDLE;
        wcnt_d  = '0;
      end
    endcase
  end

  // Response queue next state: age countdowns, pop retiring head, append new grant.
  always_comb begin
    sh_s = q_q;
    for (int i = 0; i < 2; i++) begin
      if (q_q[i].vld && (q_q[i].cnt != 4'd0)) begin
        sh_s[i].cnt = q_q[i].cnt - 4'd1;
      end else begin
        sh_s[i].cnt = q_q[i].cnt;
      end
    end
    if (retire_s) begin
      sh_s[0] = sh_s[1];
      sh_s[1] = '0;
    end else begin
      sh_s[1] = sh_s[1];
    end
    q_d = sh_s;
    if (gnt_s && !sh_s[0].vld) begin
      q_d[0] = push_s;
    end else if (gnt_s) begin
      q_d[1] = push_s;
    end else begin
      q_d[1] = sh_s[1];
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= G_IDLE;
      wcnt_q  <= '0;
      q_q[0]  <= '0;
      q_q[1]  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      q_q[0]  <= q_d[0];
      q_q[1]  <= q_d[1];
    end
  end

  // Backdoor write; storage is deliberately not reset. Reads see pre-edge contents.
  always_ff @(posedge clk) begin
    if (load_we_i) begin
      mem_q[load_addr_i[AW+1:2]] <= load_wdata_i;
    end
  end

  assign instr_gnt_o    = gnt_s;
  assign instr_rvalid_o = retire_s;
  assign instr_rdata_o  = (retire_s && !q_q[0].err) ? mem_q[q_q[0].idx] : 32'd0;
  assign busy_o         = q_q[0].vld || (state_q != G_IDLE);
`ifdef RISCV_IMEM_ERR_EN
  assign instr_err_o    = retire_s && q_q[0].err;
`endif

endmodule

// File: tb/tb_riscv_instr_mem_resp.sv
// Bench for riscv_instr_mem_resp: three instances (default, GNT_LAT=2, RVALID_LAT=3),
// table-driven single fetches, hand-written latency/abort/reset sequences, per-instance scoreboard.
module tb_riscv_instr_mem_resp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_s    [3];
  logic [31:0] addr_s   [3];
  logic        gnt_s    [3];
  logic        rvalid_s [3];
  logic        busy_s   [3];
  logic [31:0] rdata_s  [3];
`ifdef RISCV_IMEM_ERR_EN
  logic        err_s    [3];
`endif
  logic        load_we;
  logic [31:0] load_addr;
  logic [31:0] load_wdata;

  logic [31:0] tb_mem [1024];
  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] ld_addr;
    logic [31:0] ld_data;
    logic [31:0] f_addr;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;
  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [32:0] model(input logic [31:0] a);
    logic e;
`ifdef RISCV_IMEM_ERR_EN
    e = |a[31:12];
`else
    e = 1'b0;
`endif
    return {e, e ? 32'd0 : tb_mem[a[11:2]]};
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    logic [32:0] sbq [$];
    logic [32:0] exp_e;

    riscv_instr_mem_resp #(
      .MEM_WORDS (1024),
      .GNT_LAT   ((gi == 1) ? 2 : 0),
      .RVALID_LAT((gi == 2) ? 3 : 1)
    ) u_dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .instr_req_i   (req_s[gi]),
      .instr_addr_i  (addr_s[gi]),
      .instr_gnt_o   (gnt_s[gi]),
      .instr_rvalid_o(rvalid_s[gi]),
      .instr_rdata_o (rdata_s[gi]),
`ifdef RISCV_IMEM_ERR_EN
      .instr_err_o   (err_s[gi]),
`endif
      .load_we_i     (load_we),
      .load_addr_i   (load_addr),
      .load_wdata_i  (load_wdata),
      .busy_o        (busy_s[gi])
    );

    // Retire first: a same-cycle grant is always younger than the head.
    always @(negedge clk) begin
      if (!rst_n) begin
        sbq.delete();
      end else begin
        if (rvalid_s[gi]) begin
          chk("sb_nonempty", 32'(sbq.size() != 0), 32'd1);
          if (sbq.size() != 0) begin
            exp_e = sbq.pop_front();
            chk("sb_rdata", rdata_s[gi], exp_e[31:0]);
`ifdef RISCV_IMEM_ERR_EN
            chk("sb_err", 32'(err_s[gi]), 32'(exp_e[32]));
`endif
          end
        end
        if (gnt_s[gi]) sbq.push_back(model(addr_s[gi]));
      end
    end
  end

  task automatic load_word(input logic [31:0] a, input logic [31:0] d);
    load_we = 1'b1; load_addr = a; load_wdata = d;
    @(posedge clk); #1;
    load_we = 1'b0;
    tb_mem[a[11:2]] = d;
  endtask

  task automatic fetch1(input logic [31:0] a, input logic [31:0] exp_d);
    req_s[0] = 1'b1; addr_s[0] = a;
    @(negedge clk);
    chk("fetch_gnt", 32'(gnt_s[0]), 32'd1);
    chk("fetch_rvalid_early", 32'(rvalid_s[0]), 32'd0);
    @(posedge clk); #1;
    req_s[0] = 1'b0; addr_s[0] = 32'h0;
    @(negedge clk);
    chk("fetch_rvalid", 32'(rvalid_s[0]), 32'd1);
    chk("fetch_rdata", rdata_s[0], exp_d);
    chk("fetch_busy", 32'(busy_s[0]), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs[0] = '{32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0};
    vecs[1] = '{32'h0000_0000, 32'h1111_1111, 32'h0000_0000, 32'h1111_1111, 1'b0};
    vecs[2] = '{32'h0000_0FFC, 32'hA5A5_A5A5, 32'h0000_0FFE, 32'hA5A5_A5A5, 1'b0};
    vecs[3] = '{32'h0000_0004, 32'h1234_5678, 32'h0000_0007, 32'h1234_5678, 1'b0};
`ifdef RISCV_IMEM_ERR_EN
    vecs[4] = '{32'h0000_0008, 32'hCAFE_F00D, 32'h0000_1008, 32'h0000_0000, 1'b1};
`else
    vecs[4] = '{32'h0000_0008, 32'hCAFE_F00D, 32'h0000_1008, 32'hCAFE_F00D, 1'b0};
`endif
    vecs[5] = '{32'h0000_0020, 32'h8888_8888, 32'h0000_0020, 32'h8888_8888, 1'b0};
    vecs[6] = '{32'h0000_0040, 32'h4040_4040, 32'h0000_0040, 32'h4040_4040, 1'b0};

    load_we = 1'b0; load_addr = 32'h0; load_wdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      req_s[i] = 1'b0; addr_s[i] = 32'h0;
    end
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #11;
    for (int i = 0; i < 3; i++) begin
      chk("rst_gnt", 32'(gnt_s[i]), 32'd0);
      chk("rst_rvalid", 32'(rvalid_s[i]), 32'd0);
      chk("rst_busy", 32'(busy_s[i]), 32'd0);
      chk("rst_rdata", rdata_s[i], 32'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Table: load a word, fetch it (with low-bit and aliasing variations) on the default instance.
    for (int i = 0; i < 7; i++) begin
      load_word(vecs[i].ld_addr, vecs[i].ld_data);
      req_s[0] = 1'b1; addr_s[0] = vecs[i].f_addr;
      @(negedge clk);
      chk("vec_gnt", 32'(gnt_s[0]), 32'd1);
      chk("vec_busy_idle", 32'(busy_s[0]), 32'd0);
      @(posedge clk); #1;
      req_s[0] = 1'b0; addr_s[0] = 32'h0;
      @(negedge clk);
      chk("vec_rvalid", 32'(rvalid_s[0]), 32'd1);
      chk("vec_rdata", rdata_s[0], vecs[i].exp_data);
`ifdef RISCV_IMEM_ERR_EN
      chk("vec_err", 32'(err_s[0]), 32'(vecs[i].exp_err));
`endif
      @(posedge clk); #1;
    end

    // Continuous requests: grant every cycle, rvalid every cycle after the first.
    for (int i = 0; i < 4; i++) begin
      req_s[0] = 1'b1; addr_s[0] = (i == 3) ? 32'h10 : 32'(i * 4);
      @(negedge clk);
      chk("cont_gnt", 32'(gnt_s[0]), 32'd1);
      chk("cont_rvalid", 32'(rvalid_s[0]), 32'(i > 0));
      @(posedge clk); #1;
    end
    req_s[0] = 1'b0;
    @(negedge clk);
    chk("cont_rvalid_last", 32'(rvalid_s[0]), 32'd1);
    @(posedge clk); #1;

    // Write to the word being returned this cycle: old data comes back.
    req_s[0] = 1'b1; addr_s[0] = 32'h10;
    @(posedge clk); #1;
    req_s[0] = 1'b0;
    load_we = 1'b1; load_addr = 32'h10; load_wdata = 32'h0BAD_F00D;
    @(negedge clk);
    chk("wr_same_cycle_old", rdata_s[0], 32'hDEAD_BEEF);
    @(posedge clk); #1;
    load_we = 1'b0;
    tb_mem[4] = 32'h0BAD_F00D;
    fetch1(32'h10, 32'h0BAD_F00D);

    // GNT_LAT=2: address changes during the wait; grant in the third req cycle.
    req_s[1] = 1'b1; addr_s[1] = 32'h0;
    @(negedge clk);
    chk("glat_gnt_c1", 32'(gnt_s[1]), 32'd0);
    chk("glat_busy_c1", 32'(busy_s[1]), 32'd0);
    @(posedge clk); #1;
    addr_s[1] = 32'h8;
    @(negedge clk);
    chk("glat_gnt_c2", 32'(gnt_s[1]), 32'd0);
    chk("glat_busy_c2", 32'(busy_s[1]), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("glat_gnt_c3", 32'(gnt_s[1]), 32'd1);
    @(posedge clk); #1;
    req_s[1] = 1'b0;
    @(negedge clk);
    chk("glat_rvalid", 32'(rvalid_s[1]), 32'd1);
    chk("glat_rdata", rdata_s[1], 32'hCAFE_F00D);
    @(posedge clk); #1;
    // Request dropped during the wait: back to idle without a grant.
    req_s[1] = 1'b1; addr_s[1] = 32'h4;
    @(negedge clk);
    chk("gabort_gnt", 32'(gnt_s[1]), 32'd0);
    @(posedge clk); #1;
    req_s[1] = 1'b0;
    @(negedge clk);
    chk("gabort_busy_wait", 32'(busy_s[1]), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("gabort_busy_idle", 32'(busy_s[1]), 32'd0);
    chk("gabort_rvalid", 32'(rvalid_s[1]), 32'd0);
    @(posedge clk); #1;

    // RVALID_LAT=3: third grant held until the head retires; responses in order.
    req_s[2] = 1'b1; addr_s[2] = 32'h0;
    @(negedge clk); chk("rlat_gnt1", 32'(gnt_s[2]), 32'd1);
    @(posedge clk); #1; addr_s[2] = 32'h4;
    @(negedge clk); chk("rlat_gnt2", 32'(gnt_s[2]), 32'd1);
    @(posedge clk); #1; addr_s[2] = 32'h8;
    @(negedge clk);
    chk("rlat_gnt3_held", 32'(gnt_s[2]), 32'd0);
    chk("rlat_rvalid_c3", 32'(rvalid_s[2]), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rlat_gnt3", 32'(gnt_s[2]), 32'd1);
    chk("rlat_rvalid_c4", 32'(rvalid_s[2]), 32'd1);
    chk("rlat_rdata0", rdata_s[2], 32'h1111_1111);
    @(posedge clk); #1; req_s[2] = 1'b0;
    @(negedge clk);
    chk("rlat_rvalid_c5", 32'(rvalid_s[2]), 32'd1);
    chk("rlat_rdata1", rdata_s[2], 32'h1234_5678);
    @(posedge clk); #1;
    @(negedge clk); chk("rlat_rvalid_c6", 32'(rvalid_s[2]), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rlat_rvalid_c7", 32'(rvalid_s[2]), 32'd1);
    chk("rlat_rdata2", rdata_s[2], 32'hCAFE_F00D);
    @(posedge clk); #1;

    // Granted request survives req drop and an unrequested address.
    req_s[0] = 1'b1; addr_s[0] = 32'h20;
    @(negedge clk); chk("drop_gnt", 32'(gnt_s[0]), 32'd1);
    @(posedge clk); #1; req_s[0] = 1'b0; addr_s[0] = 32'h40;
    @(negedge clk);
    chk("drop_gnt_low", 32'(gnt_s[0]), 32'd0);
    chk("drop_rvalid", 32'(rvalid_s[0]), 32'd1);
    chk("drop_rdata", rdata_s[0], 32'h8888_8888);
    @(posedge clk); #1;
    @(negedge clk);
    chk("drop_no_second", 32'(rvalid_s[0]), 32'd0);
    chk("drop_busy", 32'(busy_s[0]), 32'd0);
    @(posedge clk); #1;

    // Reset with two outstanding: outputs clear at once, nothing returns afterwards.
    req_s[2] = 1'b1; addr_s[2] = 32'h0;
    @(posedge clk); #1; addr_s[2] = 32'h4;
    @(posedge clk); #1; addr_s[2] = 32'h8;
    rst_n = 1'b0;
    #1;
    chk("mrst_gnt", 32'(gnt_s[2]), 32'd0);
    chk("mrst_rvalid", 32'(rvalid_s[2]), 32'd0);
    chk("mrst_busy", 32'(busy_s[2]), 32'd0);
    chk("mrst_rdata", rdata_s[2], 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; req_s[2] = 1'b0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rvalid_s[2]) n++;
    end
    chk("mrst_no_rvalid", 32'(n), 32'd0);
    @(posedge clk); #1;
    req_s[2] = 1'b1; addr_s[2] = 32'h0;
    @(negedge clk); chk("mrst_regnt", 32'(gnt_s[2]), 32'd1);
    @(posedge clk); #1; req_s[2] = 1'b0;
    n = 0;
    for (int i = 0; i < 5 && n == 0; i++) begin
      @(negedge clk);
      if (rvalid_s[2]) begin
        n = 1;
        chk("mrst_mem_intact", rdata_s[2], 32'h1111_1111);
      end
    end
    chk("mrst_reread_rvalid", 32'(n), 32'd1);
    @(posedge clk); #1;

`ifdef RISCV_IMEM_ERR_EN
    // Out-of-range fetch reports an error with zero data.
    req_s[0] = 1'b1; addr_s[0] = 32'h0000_1000;
    @(posedge clk); #1; req_s[0] = 1'b0;
    @(negedge clk);
    chk("err_rvalid", 32'(rvalid_s[0]), 32'd1);
    chk("err_flag", 32'(err_s[0]), 32'd1);
    chk("err_rdata", rdata_s[0], 32'd0);
    @(posedge clk); #1;
`endif

    repeat (4) @(posedge clk);
    #1;
    chk("sb_drain0", 32'(g_dut[0].sbq.size()), 32'd0);
    chk("sb_drain1", 32'(g_dut[1].sbq.size()), 32'd0);
    chk("sb_drain2", 32'(g_dut[2].sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/riscv_instr_mem_resp.md
RISCV_INSTR_MEM_RESP -- requirements
Module: riscv_instr_mem_resp

Interface
REQ-001 The block SHALL have parameter MEM_WORDS, default 1024, meaning the storage depth in 32-bit words (power of 2).
REQ-002 The block SHALL have parameter GNT_LAT, default 0, meaning the number of cycles instr_req_i is held before instr_gnt_o may assert.
REQ-003 The block SHALL have parameter RVALID_LAT, default 1, meaning the number of cycles from the grant edge to instr_rvalid_o (legal range 1..8).
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 instr_req_i  input  1  fetch request from the initiator.
REQ-007 instr_addr_i  input  32  byte address of the fetch; bits [1:0] ignored.
REQ-008 instr_gnt_o  output  1  request accepted; address sampled this cycle.
REQ-009 instr_rvalid_o  output  1  instr_rdata_o is valid this cycle.
REQ-010 instr_rdata_o  output  32  fetched word.
REQ-011 load_we_i  input  1  backdoor write strobe.
REQ-012 load_addr_i  input  32  backdoor word-aligned byte address.
REQ-013 load_wdata_i  input  32  backdoor write data.
REQ-014 busy_o  output  1  high while any granted request has no rvalid yet, or the grant FSM is not in G_IDLE.

Function
REQ-015 Word index SHALL be addr[log2(MEM_WORDS)+1:2].
REQ-016 Grant FSM states SHALL be G_IDLE, G_WAIT; G_IDLE->G_WAIT on instr_req_i when GNT_LAT>0; G_WAIT counts req-high cycles and returns to G_IDLE on grant or on instr_req_i low.
REQ-017 instr_gnt_o SHALL be combinational: instr_req_i & latency met (GNT_LAT=0: same cycle; else after GNT_LAT cycles in G_WAIT) & slot available.
REQ-018 Slot available SHALL mean fewer than 2 outstanding requests, or exactly 2 with the head retiring (rvalid) this cycle.
REQ-019 instr_addr_i SHALL be sampled only in the grant cycle; changes during G_WAIT take effect (no stale address).
REQ-020 Each granted request SHALL enter a 2-entry in-order response queue holding word index and countdown loaded with RVALID_LAT-1.
REQ-021 Countdowns of all valid entries SHALL decrement by 1 each cycle while nonzero.
REQ-022 instr_rvalid_o SHALL equal head valid & head countdown==0; the head retires that cycle; at most one rvalid per cycle.
REQ-023 instr_rdata_o SHALL be mem[head index] when instr_rvalid_o, else 0.
REQ-024 Every granted request SHALL receive exactly one rvalid, in grant order, regardless of later instr_req_i/addr activity (initiator aborts are its own concern).
REQ-025 Simultaneous grant and retire SHALL keep the queue count unchanged.
REQ-026 With RVALID_LAT=1, GNT_LAT=0, continuous req SHALL yield gnt and rvalid every cycle.
REQ-027 load_we_i SHALL write mem[load index] on the clock edge; a same-cycle rvalid to that word SHALL return the old data.

Reset
REQ-028 On rst_n low: instr_gnt_o, instr_rvalid_o, busy_o, instr_rdata_o = 0; queue empty; FSM G_IDLE; counters 0.
REQ-029 Reset mid-operation SHALL discard pending responses; no rvalid for them after release.
REQ-030 Memory contents SHALL NOT be cleared by reset.

Configuration
REQ-031 With RISCV_IMEM_ERR_EN defined, output instr_err_o (1 bit, reset 0) SHALL assert with instr_rvalid_o when addr[31:log2(MEM_WORDS)+2] != 0, and instr_rdata_o SHALL be 0 for that response.
REQ-032 Without RISCV_IMEM_ERR_EN, instr_err_o SHALL not exist and out-of-range addresses SHALL alias by truncation.

Verification
REQ-033 GNT_LAT=0,RVALID_LAT=1; mem[4]=0xDEADBEEF; req addr 0x10 one cycle -> gnt same cycle, rvalid next cycle, rdata 0xDEADBEEF.
REQ-034 GNT_LAT=2; req held at 0x0 then addr changed to 0x8 in 2nd wait cycle -> gnt in 3rd req cycle, returns mem[2].
REQ-035 RVALID_LAT=3; req 0x0,0x4 back-to-back, third req 0x8 -> third gnt held low until first rvalid cycle, rvalids in order mem[0],mem[1],mem[2].
REQ-036 Grant 0x20 then drop req and present 0x40 unrequested -> one rvalid with mem[8] only.
REQ-037 rst_n low with 2 outstanding -> outputs 0 immediately, no rvalid after release, mem contents intact on next read.
REQ-038 RISCV_IMEM_ERR_EN, MEM_WORDS=1024, req 0x00001000 -> rvalid with instr_err_o=1, rdata 0.
